// File: rtl/scgra_run_ctrl.sv
// scgra_run_ctrl: turns a register-level start into iterated SCGRA core runs, each gated by
// the DMA input/output buffer handshake. Define SCGRA_RUN_PERF_CNT_EN to add perf_cycles.
`default_nettype none

module scgra_run_ctrl #(
    parameter int CNT_W     = 16,
    parameter int ITER_W    = 16,
    parameter int DRAIN_LAT = 4
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_run_len,
    input  logic [ITER_W-1:0] cfg_iter,
    input  logic              in_buf_valid,
    output logic              in_buf_ack,
    input  logic              out_buf_ready,
    output logic              out_buf_valid,
    output logic              cgra_en,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_done
`ifdef SCGRA_RUN_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_IO = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_POST    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_DRAIN = CNT_W'(DRAIN_LAT);
    localparam logic [ITER_W-1:0] ITER_ZERO = {ITER_W{1'b0}};
    localparam logic [ITER_W-1:0] ITER_ONE  = {{(ITER_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  r_run_len;
    logic [CNT_W-1:0]  w_run_len_nxt;
    logic [ITER_W-1:0] r_iter_cfg;
    logic [ITER_W-1:0] w_iter_cfg_nxt;
    logic [ITER_W-1:0] r_iter_done;
    logic [ITER_W-1:0] w_iter_done_nxt;
    logic [ITER_W-1:0] w_iter_inc;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_ack;
    logic              w_ack_nxt;
    logic              w_start_acc;
    logic              r_cgra_en;
    logic              r_busy;
    logic              r_obv;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_iter_inc  = r_iter_done + ITER_ONE;

    // Next-state, counter and status decode; abort overrides every transition out of a busy state.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_run_len_nxt   = r_run_len;
        w_iter_cfg_nxt  = r_iter_cfg;
        w_iter_done_nxt = r_iter_done;
        w_done_nxt      = r_done;
        w_ack_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) begin
                    w_run_len_nxt   = cfg_run_len;
                    w_iter_cfg_nxt  = cfg_iter;
                    w_iter_done_nxt = ITER_ZERO;
                    w_done_nxt      = 1'b0;
                    w_state_nxt     = (cfg_iter == ITER_ZERO) ? S_DONE : S_WAIT_IO;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_IO: begin
                if (in_buf_valid && out_buf_ready) begin
                    w_cnt_nxt   = (r_run_len == CNT_ZERO) ? CNT_ONE : r_run_len;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_WAIT_IO;
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_ONE) begin
                    w_cnt_nxt   = CNT_DRAIN;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_DRAIN: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = S_POST;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_POST: begin
                w_iter_done_nxt = w_iter_inc;
                w_state_nxt     = (w_iter_inc == r_iter_cfg) ? S_DONE : S_WAIT_IO;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt     = S_IDLE;
            w_iter_done_nxt = r_iter_done;
            w_ack_nxt       = 1'b0;
        end else begin
            w_ack_nxt = w_ack_nxt;
        end

        if (w_state_nxt == S_DONE) begin
            w_done_nxt = 1'b1;
        end else begin
            w_done_nxt = w_done_nxt;
        end
    end

    // State register and shadow configuration.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state     <= S_IDLE;
            r_cnt       <= CNT_ZERO;
            r_run_len   <= CNT_ZERO;
            r_iter_cfg  <= ITER_ZERO;
            r_iter_done <= ITER_ZERO;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_run_len   <= w_run_len_nxt;
            r_iter_cfg  <= w_iter_cfg_nxt;
            r_iter_done <= w_iter_done_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Outputs registered from the next-state decode so they line up with the state they describe.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_ack     <= 1'b0;
            r_cgra_en <= 1'b0;
            r_busy    <= 1'b0;
            r_obv     <= 1'b0;
        end else begin
            r_ack     <= w_ack_nxt;
            r_cgra_en <= (w_state_nxt == S_RUN);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_obv     <= (w_state_nxt == S_POST);
        end
    end

    assign in_buf_ack    = r_ack;
    assign cgra_en       = r_cgra_en;
    assign busy          = r_busy;
    assign out_buf_valid = r_obv;
    assign done          = r_done;
    assign iter_done     = r_iter_done;

`ifdef SCGRA_RUN_PERF_CNT_EN
    logic [31:0] r_perf;

    // Saturating count of busy cycles, restarted by an accepted start.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_perf <= 32'h0000_0000;
        end else if (w_start_acc) begin
            r_perf <= 32'h0000_0000;
        end else if (r_busy && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'h0000_0001;
        end else begin
            r_perf <= r_perf;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_scgra_run_ctrl.sv
// Self-checking bench for scgra_run_ctrl: a timestamp-based behavioural model checked every
// cycle, plus directed scenarios with hand-computed pulse counts and latencies.
`timescale 1ns/1ps

module tb_scgra_run_ctrl;
    localparam int CNT_W  = 16;
    localparam int ITER_W = 16;
    localparam int D      = 4;

    logic              ACLK = 1'b0;
    logic              ARESETN;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  cfg_run_len;
    logic [ITER_W-1:0] cfg_iter;
    logic              in_buf_valid;
    logic              in_buf_ack;
    logic              out_buf_ready;
    logic              out_buf_valid;
    logic              cgra_en;
    logic              busy;
    logic              done;
    logic [ITER_W-1:0] iter_done;
`ifdef SCGRA_RUN_PERF_CNT_EN
    logic [31:0]       perf_cycles;
`endif

    always #5 ACLK = ~ACLK;

    scgra_run_ctrl #(.CNT_W(CNT_W), .ITER_W(ITER_W), .DRAIN_LAT(D)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .abort(abort),
        .cfg_run_len(cfg_run_len), .cfg_iter(cfg_iter),
        .in_buf_valid(in_buf_valid), .in_buf_ack(in_buf_ack),
        .out_buf_ready(out_buf_ready), .out_buf_valid(out_buf_valid),
        .cgra_en(cgra_en), .busy(busy), .done(done), .iter_done(iter_done)
`ifdef SCGRA_RUN_PERF_CNT_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: a run is described by timestamps, not states.
    bit          m_active, m_wait, m_fin, m_done;
    int          m_acc, m_L, m_iter_cfg, m_iter;
    int unsigned m_perf;

    int n_ack = 0, n_obv = 0, n_en = 0, n_busy = 0;
    int ack_cyc = 0, obv_cyc = 0, en_run = 0;
    int en_runs[$];
    bit en_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        if (!ARESETN) begin
            m_active = 0; m_wait = 0; m_fin = 0; m_done = 0;
            m_acc = -1000; m_iter = 0; m_perf = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active   = 1;
                m_L        = (cfg_run_len == 0) ? 1 : int'(cfg_run_len);
                m_iter_cfg = int'(cfg_iter);
                m_done = 0; m_iter = 0; m_perf = 0; m_acc = -1000;
                if (cfg_iter == 0) begin
                    m_fin = 1; m_wait = 0; m_done = 1;
                end else begin
                    m_fin = 0; m_wait = 1;
                end
            end
        end else begin
            if (m_perf != 32'hFFFF_FFFF) m_perf++;
            if (abort) begin
                m_active = 0; m_wait = 0; m_fin = 0; m_acc = -1000;
            end else if (m_fin) begin
                m_active = 0; m_fin = 0;
            end else if (m_wait) begin
                if (in_buf_valid && out_buf_ready) begin
                    m_wait = 0; m_acc = cyc;
                end
            end else if (cyc - 1 == m_acc + m_L + D) begin
                m_iter++;
                m_acc = -1000;
                if (m_iter == m_iter_cfg) begin
                    m_fin = 1; m_done = 1;
                end else begin
                    m_wait = 1;
                end
            end
        end
    endtask

    task automatic tick();
        bit run;
        @(posedge ACLK);
        cyc++;
        model_step();
        #1;
        run = m_active && !m_wait && !m_fin && (m_acc >= 0);
        chk("busy", busy, m_active);
        chk("done", done, m_done);
        chk("iter_done", iter_done, m_iter);
        chk("in_buf_ack", in_buf_ack, run && (cyc == m_acc));
        chk("cgra_en", cgra_en, run && (cyc >= m_acc) && (cyc <= m_acc + m_L - 1));
        chk("out_buf_valid", out_buf_valid, run && (cyc == m_acc + m_L + D));
`ifdef SCGRA_RUN_PERF_CNT_EN
        chk("perf_cycles", perf_cycles, m_perf);
`endif
        if (in_buf_ack)    begin n_ack++; ack_cyc = cyc; end
        if (out_buf_valid) begin n_obv++; obv_cyc = cyc; end
        if (busy) n_busy++;
        if (cgra_en) begin n_en++; en_run++; end
        if (!cgra_en && en_prev) begin en_runs.push_back(en_run); en_run = 0; end
        en_prev = cgra_en;
        @(negedge ACLK);
    endtask

    task automatic pulse_start(input int len, input int it, input bit ab);
        start = 1'b1; abort = ab;
        cfg_run_len = CNT_W'(len); cfg_iter = ITER_W'(it);
        tick();
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i = 0;
        while (busy === 1'b1 && i < budget) begin
            tick();
            i++;
        end
        chk({name, "_idle"}, busy, 1'b0);
    endtask

    int b_ack, b_obv, b_en, b_busy, b_runs, r_cyc;

    task automatic snap();
        b_ack = n_ack; b_obv = n_obv; b_en = n_en; b_busy = n_busy; b_runs = en_runs.size();
    endtask

    initial begin
        ARESETN = 1'b0; start = 1'b0; abort = 1'b0;
        in_buf_valid = 1'b0; out_buf_ready = 1'b0;
        cfg_run_len = '0; cfg_iter = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_cgra_en", cgra_en, 0);
        chk("rst_done", done, 0);
        chk("rst_iter", iter_done, 0);
        ARESETN = 1'b1;
        tick();

        // Normal run: 8 x 3, buffers held ready.
        in_buf_valid = 1'b1; out_buf_ready = 1'b1;
        snap();
        pulse_start(8, 3, 1'b0);
        wait_idle("t1", 200);
        chk("t1_acks", n_ack - b_ack, 3);
        chk("t1_obvs", n_obv - b_obv, 3);
        chk("t1_en_cycles", n_en - b_en, 24);
        chk("t1_busy_cycles", n_busy - b_busy, 43);
        chk("t1_en_runs", en_runs.size() - b_runs, 3);
        for (int i = b_runs; i < en_runs.size(); i++) chk("t1_en_run_len", en_runs[i], 8);
        chk("t1_iter", iter_done, 3);
        chk("t1_done", done, 1);
`ifdef SCGRA_RUN_PERF_CNT_EN
        chk("t1_perf", perf_cycles, 43);
`endif

        // Zero iterations.
        snap();
        pulse_start(5, 0, 1'b0);
        wait_idle("t2", 20);
        chk("t2_busy_cycles", n_busy - b_busy, 1);
        chk("t2_done", done, 1);
        chk("t2_en", n_en - b_en, 0);
        chk("t2_acks", n_ack - b_ack, 0);
        chk("t2_obvs", n_obv - b_obv, 0);

        // Zero run length, with abort alongside start in IDLE.
        snap();
        pulse_start(0, 1, 1'b1);
        chk("t3_start_wins", busy, 1);
        wait_idle("t3", 50);
        chk("t3_en", n_en - b_en, 1);
        chk("t3_ack_to_obv", obv_cyc - ack_cyc, 5);
        chk("t3_iter", iter_done, 1);

        // Backpressure on the output buffer.
        out_buf_ready = 1'b0;
        snap();
        pulse_start(4, 1, 1'b0);
        repeat (20) tick();
        chk("t4_no_en", n_en - b_en, 0);
        chk("t4_busy", busy, 1);
        out_buf_ready = 1'b1;
        r_cyc = cyc;
        tick();
        chk("t4_ack_cycle", ack_cyc - r_cyc, 1);
        chk("t4_en_now", cgra_en, 1);
        wait_idle("t4", 50);
        chk("t4_en", n_en - b_en, 4);

        // Abort in the RUN of iteration 2 of 4, then restart.
        snap();
        pulse_start(8, 4, 1'b0);
        begin
            int i = 0;
            while (n_ack < b_ack + 2 && i < 100) begin tick(); i++; end
        end
        chk("t5_wait_ack", n_ack - b_ack, 2);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_en", cgra_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_iter", iter_done, 1);
        tick();
        pulse_start(2, 1, 1'b0);
        chk("t5_restart_iter", iter_done, 0);
        wait_idle("t5", 50);
        chk("t5_restart_done", iter_done, 1);

        // start while busy with new cfg is ignored.
        snap();
        pulse_start(3, 2, 1'b0);
        repeat (5) tick();
        cfg_run_len = 16'd10; cfg_iter = 16'd5; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("t6", 200);
        chk("t6_iter", iter_done, 2);
        chk("t6_acks", n_ack - b_ack, 2);
        chk("t6_en", n_en - b_en, 6);

        // Reset in the middle of a run.
        pulse_start(8, 2, 1'b0);
        repeat (6) tick();
        ARESETN = 1'b0;
        tick();
        chk("t7_busy", busy, 0);
        chk("t7_en", cgra_en, 0);
        chk("t7_iter", iter_done, 0);
        chk("t7_done", done, 0);
        ARESETN = 1'b1;
        tick();
        chk("t7_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scgra_run_ctrl.md
# scgra_run_ctrl

Sequencing controller directly downstream of the acc_ctrl AXI4-Lite register slave. It converts the register-level start command and configuration words into a cycle-exact run of the SCGRA core, repeated over a configured number of iterations. Each iteration is gated by a handshake with the DMA that fills the input buffer and drains the output buffer. Busy, done and progress status are returned to the register slave for AXI readback.

## Interface
- CNT_W, 16: width of the per-iteration run length.
- ITER_W, 16: width of the iteration count and iteration progress counter.
- DRAIN_LAT, 4: cycles the core pipeline needs to flush after `cgra_en` drops; legal range 1..15.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse generated by the register slave on a write to the control register.
- abort  in  1  one-cycle pulse; cancels the current run.
- cfg_run_len  in  CNT_W  number of core cycles per iteration.
- cfg_iter  in  ITER_W  number of iterations.
- in_buf_valid  in  1  DMA has filled the input buffer.
- in_buf_ack  out  1  one-cycle pulse; the input buffer has been taken by the core.
- out_buf_ready  in  1  the output buffer is free to receive results.
- out_buf_valid  out  1  one-cycle pulse; the output buffer now holds one iteration's results.
- cgra_en  out  1  SCGRA core clock enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  sticky completion flag.
- iter_done  out  ITER_W  count of completed iterations.
- perf_cycles  out  32  total busy cycles. Present only when the macro in Configuration is defined.

## Operation
- States: IDLE, WAIT_IO, RUN, DRAIN, POST, DONE.
- IDLE
  - On `start`: latch `cfg_run_len` and `cfg_iter` into shadow registers; clear `done` and `iter_done`.
  - Next state is DONE if the latched `cfg_iter == 0`, otherwise WAIT_IO.
- WAIT_IO
  - When `in_buf_valid && out_buf_ready`: load the run counter with the shadow run length and go to RUN.
  - A shadow run length of 0 is loaded as 1.
- RUN
  - `cgra_en` is high for every cycle in this state.
  - The counter decrements each cycle. When it reaches 1, go to DRAIN; RUN therefore lasts exactly max(run_len, 1) cycles.
- DRAIN
  - `cgra_en` is low; the state lasts exactly DRAIN_LAT cycles, then go to POST.
- POST (one cycle)
  - `out_buf_valid` is high.
  - `iter_done` increments at the end of this cycle.
  - Next state is DONE if the incremented value equals the shadow `cfg_iter`, otherwise WAIT_IO.
- DONE (one cycle)
  - Set `done`, then go to IDLE.
  - `done` stays high until the next accepted `start` or reset.
- `start` while `busy` is ignored. The shadow registers are not reloaded; changes to `cfg_*` mid-run have no effect.
- `abort` in any non-IDLE state:
  - Go to IDLE on the next edge with `cgra_en` low and `done` not set.
  - `iter_done` holds its value.
  - `abort` in IDLE is ignored.
  - `abort` has priority over every other transition, including a same-cycle POST → DONE.
- `start` and `abort` asserted together in IDLE: `start` wins.
- `iter_done` is ITER_W bits. It cannot wrap, because completion is detected at equality with `cfg_iter`.

## Timing
- All outputs are registered and decoded from the state register.
- Reset values: state IDLE; `in_buf_ack`, `out_buf_valid`, `cgra_en`, `busy`, `done` all 0; `iter_done` 0; `perf_cycles` 0.
- Reset has priority over `start` and `abort`.
- Reset asserted mid-run returns the block to IDLE on the same edge, with all outputs at their reset values.
- `start` sampled at edge t gives `busy` = 1 from t+1.
- For a WAIT_IO condition sampled at edge c:
  - `in_buf_ack` is high in cycle c+1 only.
  - `cgra_en` is high in cycles c+1 .. c+L, where L = max(run_len, 1).
  - DRAIN occupies c+L+1 .. c+L+DRAIN_LAT.
  - `out_buf_valid` is high in cycle c+L+DRAIN_LAT+1.
- Per-iteration overhead is DRAIN_LAT + 2 cycles beyond L when the buffers are already ready.
- `done` rises one cycle after the final `out_buf_valid`; `busy` falls one cycle after that.

## Configuration
- `SCGRA_RUN_PERF_CNT_EN` defined:
  - `perf_cycles` exists.
  - Cleared on an accepted `start`; increments every cycle while `busy`; saturates at 0xFFFFFFFF.
  - Holds its value in IDLE.
- Not defined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- Normal run: run_len = 8, iter = 3, DRAIN_LAT = 4, buffers held ready → 3 `in_buf_ack`/`out_buf_valid` pulse pairs; `cgra_en` high for 8 consecutive cycles per iteration; `iter_done` = 3; `done` = 1; with the macro, `perf_cycles` = 43.
- Zero iterations: iter = 0 → `busy` high for exactly 1 cycle, `done` = 1, no `cgra_en`, no pulses.
- Zero run length: run_len = 0, iter = 1 → `cgra_en` high for exactly 1 cycle; `out_buf_valid` 5 cycles after `in_buf_ack`.
- Backpressure: `out_buf_ready` low for 20 cycles in WAIT_IO → `cgra_en` stays 0; the run proceeds on the cycle after `out_buf_ready` rises.
- Abort mid-RUN during iteration 2 of 4 → `cgra_en` low on the next cycle; `busy` = 0; `done` = 0; `iter_done` = 1. A subsequent `start` restarts from `iter_done` = 0.
- `start` pulsed while busy with new cfg values → ignored; the run completes using the original run_len and iter.
